// File: rtl/dac_pair_interleaver.sv
// dac_pair_interleaver
// Buffers signed two-channel sample pairs in a small FIFO and saturates each
// sample to DAC width on entry. The pairs are then serialised onto a single
// DAC bus as channel A then channel B words, each qualified by an active-low
// write strobe.
module dac_pair_interleaver #(
    parameter int DW         = 16,
    parameter int AW         = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          dac_clk_i,
    input  logic                          dac_rstn_i,
    input  logic                          en_i,
    input  logic                          clr_i,
    input  logic [DW-1:0]                 s_dat_a_i,
    input  logic [DW-1:0]                 s_dat_b_i,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    output logic [AW-1:0]                 dac_dat_o,
    output logic                          dac_sel_o,
    output logic                          dac_wrt_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_lvl_o,
    output logic                          underflow_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
    // enc(0): mid-scale code
    localparam logic [AW-1:0] MID_CODE = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] SAT_MAX  = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] SAT_MIN  = {1'b1, {(AW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CHA, CHB} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   lvl_q, lvl_d;
    logic [AW-1:0]   hold_a_q, hold_a_d;
    logic [AW-1:0]   hold_b_q, hold_b_d;
    logic [AW-1:0]   dat_q, dat_d;
    logic            sel_q, sel_d;
    logic            wrt_q, wrt_d;
    logic            uf_q, uf_d;

    logic [AW-1:0]   mem_a [FIFO_DEPTH];
    logic [AW-1:0]   mem_b [FIFO_DEPTH];

    logic            push;
    logic            pop;
    logic            uf_set;

    // Clamp a signed DW-bit sample into the signed AW-bit range
    function automatic logic [AW-1:0] sat(input logic [DW-1:0] s);
        logic [DW-AW:0] top;
        top = s[DW-1:AW-1];
        if ((&top) || !(|top))
            return s[AW-1:0];
        else if (s[DW-1])
            return SAT_MIN;
        else
            return SAT_MAX;
    endfunction

    // Offset-inverted DAC code: sign bit kept, magnitude bits inverted
    function automatic logic [AW-1:0] enc(input logic [AW-1:0] s);
        return {s[AW-1], ~s[AW-2:0]};
    endfunction

    assign s_ready_o   = (lvl_q != FULL_LVL);
    assign fifo_lvl_o  = lvl_q;
    assign dac_dat_o   = dat_q;
    assign dac_sel_o   = sel_q;
    assign dac_wrt_o   = wrt_q;
    assign underflow_o = uf_q;

    // Handshake qualifiers: pop only where a new pair may start
    always_comb begin
        push   = s_valid_i && s_ready_o;
        pop    = en_i && (lvl_q != '0) && ((state_q == IDLE) || (state_q == CHB));
        uf_set = en_i && (lvl_q == '0) && (state_q == CHB);
    end

    // FIFO pointers, level and hold registers
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        lvl_d    = lvl_q;
        hold_a_d = hold_a_q;
        hold_b_d = hold_b_q;
        if (push)
            wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            hold_a_d = mem_a[rd_ptr_q];
            hold_b_d = mem_b[rd_ptr_q];
        end
        if (push && !pop)
            lvl_d = lvl_q + LW'(1);
        else if (pop && !push)
            lvl_d = lvl_q - LW'(1);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en_i && (lvl_q != '0)) state_d = CHA;
            CHA:     state_d = CHB;
            CHB:     state_d = en_i ? CHA : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered bus outputs follow the state being entered; on a pop the
    // A word comes straight from the FIFO since the hold register loads on
    // the same edge
    always_comb begin
        dat_d = dat_q;
        sel_d = 1'b0;
        wrt_d = 1'b1;
        case (state_d)
            CHA: begin
                dat_d = pop ? enc(mem_a[rd_ptr_q]) : enc(hold_a_q);
                sel_d = 1'b0;
                wrt_d = 1'b0;
            end
            CHB: begin
                dat_d = enc(hold_b_q);
                sel_d = 1'b1;
                wrt_d = 1'b0;
            end
            default: begin
                dat_d = dat_q;
                sel_d = 1'b0;
                wrt_d = 1'b1;
            end
        endcase
    end

    // Sticky underflow: a set event takes priority over clear
    always_comb begin
        uf_d = uf_q;
        if (uf_set)
            uf_d = 1'b1;
        else if (clr_i)
            uf_d = 1'b0;
    end

    // State, control and output registers
    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lvl_q    <= '0;
            hold_a_q <= '0;
            hold_b_q <= '0;
            dat_q    <= MID_CODE;
            sel_q    <= 1'b0;
            wrt_q    <= 1'b1;
            uf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            lvl_q    <= lvl_d;
            hold_a_q <= hold_a_d;
            hold_b_q <= hold_b_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            wrt_q    <= wrt_d;
            uf_q     <= uf_d;
        end
    end

    // FIFO storage holds saturated samples; contents are don't-care while empty
    always_ff @(posedge dac_clk_i) begin
        if (push) begin
            mem_a[wr_ptr_q] <= sat(s_dat_a_i);
            mem_b[wr_ptr_q] <= sat(s_dat_b_i);
        end
    end

endmodule

// File: tb/tb_dac_pair_interleaver.sv
// Directed bench for dac_pair_interleaver: reset, latency, saturation,
// back-pressure, underflow/clear and disable-mid-pair behaviour.
module tb_dac_pair_interleaver;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        clr;
    logic [15:0] dat_a;
    logic [15:0] dat_b;
    logic        valid;
    logic        ready;
    logic [13:0] dac_dat;
    logic        dac_sel;
    logic        dac_wrt;
    logic [2:0]  lvl;
    logic        uf;

    int tests  = 0;
    int failed = 0;

    dac_pair_interleaver #(.DW(16), .AW(14), .FIFO_DEPTH(4)) dut (
        .dac_clk_i   (clk),
        .dac_rstn_i  (rstn),
        .en_i        (en),
        .clr_i       (clr),
        .s_dat_a_i   (dat_a),
        .s_dat_b_i   (dat_b),
        .s_valid_i   (valid),
        .s_ready_o   (ready),
        .dac_dat_o   (dac_dat),
        .dac_sel_o   (dac_sel),
        .dac_wrt_o   (dac_wrt),
        .fifo_lvl_o  (lvl),
        .underflow_o (uf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_pair(input int a, input int b);
        dat_a = 16'(a);
        dat_b = 16'(b);
    endtask

    // Expected DAC code for an in-range sample: mid-scale minus value above,
    // 0x2000 plus (-1 - value) below
    function automatic logic [31:0] code_of(input int s);
        if (s >= 0)
            return 32'(8191 - s);
        else
            return 32'(8192 + (-1 - s));
    endfunction

    // Downstream decode of a DAC code back to a signed value
    function automatic logic [31:0] decode(input logic [13:0] c);
        int v;
        if (c[13])
            v = -1 - int'(c - 14'h2000);
        else
            v = 8191 - int'(c);
        return 32'(v);
    endfunction

    task automatic chk_bus(input string tag, input logic [31:0] d, input logic s);
        chk({tag, "_dat"}, 32'(dac_dat), d);
        chk({tag, "_sel"}, 32'(dac_sel), 32'(s));
        chk({tag, "_wrt"}, 32'(dac_wrt), 32'd0);
    endtask

    initial begin
        rstn  = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        valid = 1'b0;
        set_pair(0, 0);

        // ---- power-on reset values ----
        tick();
        tick();
        chk("rst_dat", 32'(dac_dat), 32'h1FFF);
        chk("rst_wrt", 32'(dac_wrt), 32'd1);
        chk("rst_sel", 32'(dac_sel), 32'd0);
        chk("rst_rdy", 32'(ready), 32'd1);
        chk("rst_lvl", 32'(lvl), 32'd0);
        chk("rst_uf",  32'(uf), 32'd0);
        rstn = 1'b1;
        tick();

        // ---- single pair latency: A=100, B=-100 ----
        en = 1'b1;
        set_pair(100, -100);
        valid = 1'b1;
        tick();                         // cycle N+1
        valid = 1'b0;
        chk("lat_lvl1", 32'(lvl), 32'd1);
        chk("lat_wrt1", 32'(dac_wrt), 32'd1);
        tick();                         // N+2
        chk_bus("lat_a", 32'h1F9B, 1'b0);
        tick();                         // N+3
        chk_bus("lat_b", 32'h2063, 1'b1);
        en = 1'b0;
        tick();
        chk("idle_wrt", 32'(dac_wrt), 32'd1);
        chk("idle_sel", 32'(dac_sel), 32'd0);
        chk("idle_hold", 32'(dac_dat), 32'h2063);
        chk("idle_uf", 32'(uf), 32'd0);

        // ---- saturation: A=20000, B=-20000 ----
        en = 1'b1;
        set_pair(20000, -20000);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        chk_bus("sat_a", 32'h0000, 1'b0);
        chk("sat_a_dec", decode(dac_dat), 32'd8191);
        tick();
        chk_bus("sat_b", 32'h3FFF, 1'b1);
        chk("sat_b_dec", decode(dac_dat), 32'hFFFF_E000);
        en = 1'b0;
        tick();
        chk("sat_idle_wrt", 32'(dac_wrt), 32'd1);

        // ---- back-pressure: 5 pushes with output disabled ----
        valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            set_pair(k * 10, -k * 10);
            tick();
        end
        chk("bp_rdy", 32'(ready), 32'd0);
        chk("bp_lvl4", 32'(lvl), 32'd4);
        set_pair(50, -50);
        tick();                         // 5th push is refused
        chk("bp_lvl_still4", 32'(lvl), 32'd4);
        chk("bp_wrt_idle", 32'(dac_wrt), 32'd1);
        valid = 1'b0;
        en = 1'b1;
        tick();
        for (int k = 1; k <= 4; k++) begin
            chk_bus($sformatf("bp_p%0d_a", k), code_of(k * 10), 1'b0);
            tick();
            chk_bus($sformatf("bp_p%0d_b", k), code_of(-k * 10), 1'b1);
            if (k == 4) en = 1'b0;
            tick();
        end
        chk("bp_end_wrt", 32'(dac_wrt), 32'd1);
        chk("bp_end_lvl", 32'(lvl), 32'd0);
        chk("bp_end_uf", 32'(uf), 32'd0);
        chk("bp_end_rdy", 32'(ready), 32'd1);

        // ---- underflow: two pairs then input stops ----
        en = 1'b1;
        valid = 1'b1;
        set_pair(500, -500);
        tick();                         // N+1
        chk("uf_lvl1", 32'(lvl), 32'd1);
        set_pair(600, -600);
        tick();                         // N+2
        valid = 1'b0;
        chk_bus("uf_p1_a", 32'h1E0B, 1'b0);
        tick();
        chk_bus("uf_p1_b", 32'h21F3, 1'b1);
        tick();
        chk_bus("uf_p2_a", 32'h1DA7, 1'b0);
        chk("uf_flag0_a", 32'(uf), 32'd0);
        tick();
        chk_bus("uf_p2_b", 32'h2257, 1'b1);
        chk("uf_flag0_b", 32'(uf), 32'd0);
        tick();                         // first repeat
        chk_bus("uf_rep_a", 32'h1DA7, 1'b0);
        chk("uf_flag1", 32'(uf), 32'd1);
        tick();
        chk_bus("uf_rep_b", 32'h2257, 1'b1);
        clr = 1'b1;                     // clear coincides with a set event
        tick();
        chk("uf_set_wins", 32'(uf), 32'd1);
        chk_bus("uf_rep2_a", 32'h1DA7, 1'b0);
        tick();                         // clear during CHA, no event
        clr = 1'b0;
        chk("uf_cleared", 32'(uf), 32'd0);
        chk_bus("uf_rep2_b", 32'h2257, 1'b1);
        tick();
        chk("uf_reset_again", 32'(uf), 32'd1);
        chk_bus("dis_a", 32'h1DA7, 1'b0);

        // ---- disable during CHA: B still completes ----
        en = 1'b0;
        tick();
        chk_bus("dis_b", 32'h2257, 1'b1);
        tick();
        chk("dis_wrt", 32'(dac_wrt), 32'd1);
        chk("dis_sel", 32'(dac_sel), 32'd0);
        chk("dis_hold", 32'(dac_dat), 32'h2257);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        tick();
        chk("idle_no_uf", 32'(uf), 32'd0);

        // ---- asynchronous reset mid-stream ----
        valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_pair(1000 + k, -1000 - k);
            tick();
        end
        valid = 1'b0;
        en = 1'b1;
        tick();
        tick();
        chk("pre_rst_wrt", 32'(dac_wrt), 32'd0);
        #1;
        rstn = 1'b0;
        #1;
        chk("arst_dat", 32'(dac_dat), 32'h1FFF);
        chk("arst_wrt", 32'(dac_wrt), 32'd1);
        chk("arst_sel", 32'(dac_sel), 32'd0);
        chk("arst_rdy", 32'(ready), 32'd1);
        chk("arst_lvl", 32'(lvl), 32'd0);
        chk("arst_uf",  32'(uf), 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        tick();
        tick();
        chk("post_rst_wrt", 32'(dac_wrt), 32'd1);
        chk("post_rst_lvl", 32'(lvl), 32'd0);
        set_pair(-1, 0);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        chk_bus("fresh_a", 32'h2000, 1'b0);
        tick();
        chk_bus("fresh_b", 32'h1FFF, 1'b1);
        en = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
